mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's dual-port memory interface.
- Serves the data port (A: read or write under a 2-bit control) and the instruction-fetch port (B: read every CPU cycle).
- Both ports share one external asynchronous 16-bit SRAM.
- Serialises each round as data access, then instruction fetch.
- Pulses ready for exactly one cycle per completed round; the CPU advances its pipeline only on that cycle.

Parameters:
- ADDR_W, 16, width of CPU and SRAM addresses.
- DATA_W, 16, width of data words.
- ACCESS_CYCLES, 2, cycles each SRAM access occupies. Legal range 2..15; elaboration error outside it.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- a_addr  in  ADDR_W  data-port address.
- a_wdata  in  DATA_W  data-port write value.
- a_ctrl  in  2  data-port control: 00 none, 01 read, 10 write, 11 reserved (treated as none).
- b_addr  in  ADDR_W  instruction-fetch address.
- a_rdata  out  DATA_W  data-port read result.
- b_rdata  out  DATA_W  fetched instruction word.
- ready  out  1  round complete; CPU may advance.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  SRAM write data.
- sram_dout_en  out  1  drive enable for the SRAM data bus.
- sram_din  in  DATA_W  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (rst=0 at a clock edge) applies to all state and outputs:
  - state=IDLE, counter=0.
  - a_rdata=0, b_rdata=0, ready=0, sram_addr=0, sram_dout=0, sram_dout_en=0.
  - all strobes=1.
  - Reset mid-access abandons the access immediately, with no completion pulse.
- FSM states: IDLE, DATA_RD, DATA_WR, INST_RD, DONE. All outputs are registered.
- IDLE (1 cycle): samples a_addr, a_wdata, a_ctrl, b_addr into internal latches.
  - ctrl 01 -> DATA_RD.
  - ctrl 10 -> DATA_WR.
  - otherwise -> INST_RD.
  - The CPU holds its inputs stable while ready=0; the latched values govern the whole round.
- DATA_RD (ACCESS_CYCLES cycles):
  - sram_addr=a_addr latch, ce_n=0, oe_n=0, we_n=1, dout_en=0.
  - a_rdata<=sram_din on the last cycle.
  - Then -> INST_RD.
- DATA_WR (ACCESS_CYCLES cycles):
  - sram_addr=a_addr latch, sram_dout=a_wdata latch, dout_en=1, ce_n=0, oe_n=1.
  - we_n=0 on all cycles except the last; we_n=1 on the last cycle so address and data are held past the WE rising edge.
  - a_rdata unchanged.
  - Then -> INST_RD.
- INST_RD (ACCESS_CYCLES cycles): same strobes as DATA_RD with sram_addr=b_addr latch; b_rdata<=sram_din on the last cycle; then -> DONE.
- DONE (1 cycle): ready=1, all strobes=1, dout_en=0; -> IDLE.
- ready is 1 only in DONE; it is never asserted two consecutive cycles.
- Round latency from IDLE to ready:
  - fetch only: 1 + ACCESS_CYCLES.
  - data + fetch: 1 + 2·ACCESS_CYCLES.
  - ready itself occupies the following cycle.
- Counter: 4-bit down-counter loaded with ACCESS_CYCLES−1 on each access-state entry. The last cycle is when counter==0.
- Hazards:
  - Same-address write then fetch in one round: the fetch returns the newly written word.
  - a_ctrl=11 behaves exactly as 00.
  - Address inputs pass through unmodified, with no wrap logic; 0xFFFF is a legal address.
- Read results are held until overwritten by the next read of the same port.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10, MEM_RSVD=2'b11.
  - The state encoding constants.
  - The ACCESS_CYCLES legal-range bounds.
- The CPU pipeline forwarders reuse the same control codes.
- One natural sub-module, access_timer: the load/decrement counter with a last-cycle flag, instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> all outputs at reset values, strobes=1. With a_ctrl=00 and b_addr=0x0000, ready=1 exactly 4 cycles after release (ACCESS_CYCLES=2).
- Fetch only: SRAM[0x0010]=0x4A21, b_addr=0x0010, a_ctrl=00 -> exactly one ready pulse per round; b_rdata=0x4A21 when ready=1; a_rdata unchanged; we_n never low.
- Data read: SRAM[0x8000]=0xBEEF, SRAM[0x0011]=0x1234, a_ctrl=01, a_addr=0x8000, b_addr=0x0011 -> ready after 5 cycles; a_rdata=0xBEEF, b_rdata=0x1234; oe_n low 4 consecutive cycles.
- Write then same-address fetch: a_ctrl=10, a_addr=0x0020, a_wdata=0x5A5A, b_addr=0x0020 -> we_n low 1 cycle with dout_en=1; the SRAM model holds 0x5A5A; b_rdata=0x5A5A at ready.
- Reset mid-write: drop rst during the first DATA_WR cycle -> next cycle all strobes=1, dout_en=0, no ready pulse. After release, a fresh round completes normally.
- Reserved/boundary: a_ctrl=11, a_addr=0xFFFF, b_addr=0xFFFF with SRAM[0xFFFF]=0x0001 -> fetch-only timing; b_rdata=0x0001; no data access occurs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: CPU port control codes,
// responder state encoding and the legal range of the SRAM access length.
package mem_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    localparam int ACCESS_CYCLES_MIN = 2;
    localparam int ACCESS_CYCLES_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_RD = 3'd1,
        ST_DATA_WR = 3'd2,
        ST_INST_RD = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic is_access(input state_t s);
        return (s == ST_DATA_RD) || (s == ST_DATA_WR) || (s == ST_INST_RD);
    endfunction

endpackage

// File: rtl/access_timer.sv
// Down-counter that times one SRAM access; reloads on entry to an access
// state and flags the last cycle both for now and for the coming cycle.
module access_timer #(
    parameter int LOAD_VALUE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last,
    output logic last_next
);

    logic [3:0] count;
    logic [3:0] count_next;

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = 4'(LOAD_VALUE);
        end else if (count != 4'd0) begin
            count_next = count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 4'd0;
        end else begin
            count <= count_next;
        end
    end

    assign last      = (count == 4'd0);
    assign last_next = (count_next == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Serialises a data-port access and an instruction fetch onto one async SRAM
// per round, pulsing ready for one cycle when both are done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | capture CPU requests, pick first access of the round
// DATA_RD | data-port read from SRAM, ACCESS_CYCLES long
// DATA_WR | data-port write to SRAM, WE released on the last cycle
// INST_RD | instruction fetch from SRAM, ACCESS_CYCLES long
// DONE    | ready pulse, SRAM idle
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_ctrl,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    if (ACCESS_CYCLES < ACCESS_CYCLES_MIN || ACCESS_CYCLES > ACCESS_CYCLES_MAX) begin : g_bad_access
        $error("mem_responder: ACCESS_CYCLES out of range");
    end

    state_t state, next_state;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, a_addr_cur, b_addr_cur;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_cur;
    logic last, last_next, timer_load;

    access_timer #(.LOAD_VALUE(ACCESS_CYCLES - 1)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .last      (last),
        .last_next (last_next)
    );

    // The first access of a round is set up on the same edge that captures
    // the request, so it must see the live inputs rather than the latches.
    assign a_addr_cur  = (state == ST_IDLE) ? a_addr  : a_addr_q;
    assign a_wdata_cur = (state == ST_IDLE) ? a_wdata : a_wdata_q;
    assign b_addr_cur  = (state == ST_IDLE) ? b_addr  : b_addr_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                case (a_ctrl)
                    MEM_READ:  next_state = ST_DATA_RD;
                    MEM_WRITE: next_state = ST_DATA_WR;
                    default:   next_state = ST_INST_RD;
                endcase
            end
            ST_DATA_RD, ST_DATA_WR: if (last) next_state = ST_INST_RD;
            ST_INST_RD:             if (last) next_state = ST_DONE;
            ST_DONE:                next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    assign timer_load = is_access(next_state) && (next_state != state);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            a_wdata_q    <= '0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            ready        <= 1'b0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            if (state == ST_IDLE) begin
                a_addr_q  <= a_addr;
                b_addr_q  <= b_addr;
                a_wdata_q <= a_wdata;
            end
            if (state == ST_DATA_RD && last) a_rdata <= sram_din;
            if (state == ST_INST_RD && last) b_rdata <= sram_din;

            ready        <= (next_state == ST_DONE);
            sram_dout_en <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            case (next_state)
                ST_DATA_RD: begin
                    sram_addr <= a_addr_cur;
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                end
                ST_DATA_WR: begin
                    sram_addr    <= a_addr_cur;
                    sram_dout    <= a_wdata_cur;
                    sram_dout_en <= 1'b1;
                    sram_ce_n    <= 1'b0;
                    sram_we_n    <= last_next;
                end
                ST_INST_RD: begin
                    sram_addr <= b_addr_cur;
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a behavioural async SRAM; outputs are
// sampled on the falling clock edge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_addr, a_wdata, b_addr;
    logic [1:0]  a_ctrl;
    logic [15:0] a_rdata, b_rdata, sram_addr, sram_dout, sram_din;
    logic        ready, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int edges;
    int we_low, we_low_en, oe_low, oe_run, oe_run_max;
    logic found;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_ctrl       (a_ctrl),
        .b_addr       (b_addr),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .ready        (ready),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_din     (sram_din),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_din = mem[sram_addr];

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dout_en) mem[sram_addr] = sram_dout;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until ready is seen (bounded), gathering strobe statistics.
    task automatic wait_ready(input int limit);
        edges = 0; we_low = 0; we_low_en = 0; oe_low = 0; oe_run = 0; oe_run_max = 0;
        found = 1'b0;
        while (!found && edges < limit) begin
            tick();
            edges++;
            if (!sram_we_n) we_low++;
            if (!sram_we_n && sram_dout_en) we_low_en++;
            if (!sram_oe_n) begin
                oe_low++;
                oe_run++;
                if (oe_run > oe_run_max) oe_run_max = oe_run;
            end else begin
                oe_run = 0;
            end
            if (ready) found = 1'b1;
        end
        chk("ready_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'h4A21;
        mem[16'h8000] = 16'hBEEF;
        mem[16'h0011] = 16'h1234;
        mem[16'hFFFF] = 16'h0001;

        rst = 1'b0; a_ctrl = 2'b00; a_addr = 16'h0000; a_wdata = 16'h0000; b_addr = 16'h0000;
        repeat (3) tick();
        chk("rst_a_rdata", {16'd0, a_rdata}, 32'h0);
        chk("rst_b_rdata", {16'd0, b_rdata}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h0);
        chk("rst_addr", {16'd0, sram_addr}, 32'h0);
        chk("rst_dout", {16'd0, sram_dout}, 32'h0);
        chk("rst_dout_en", {31'd0, sram_dout_en}, 32'h0);
        chk("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);

        // First round after release: IDLE + 2 fetch cycles, ready in the 4th cycle.
        rst = 1'b1;
        wait_ready(20);
        chk("first_latency", edges, 3);

        // Fetch only, two back-to-back rounds.
        b_addr = 16'h0010;
        wait_ready(20);
        chk("fetch_latency", edges, 4);
        chk("fetch_b_rdata", {16'd0, b_rdata}, 32'h4A21);
        chk("fetch_a_rdata", {16'd0, a_rdata}, 32'h0);
        chk("fetch_we_low", we_low, 0);
        chk("fetch_oe_low", oe_low, 2);
        wait_ready(20);
        chk("fetch2_latency", edges, 4);
        chk("fetch2_b_rdata", {16'd0, b_rdata}, 32'h4A21);

        // Data read plus fetch.
        a_ctrl = 2'b01; a_addr = 16'h8000; b_addr = 16'h0011;
        wait_ready(20);
        chk("rd_latency", edges, 6);
        chk("rd_a_rdata", {16'd0, a_rdata}, 32'hBEEF);
        chk("rd_b_rdata", {16'd0, b_rdata}, 32'h1234);
        chk("rd_oe_run", oe_run_max, 4);
        chk("rd_we_low", we_low, 0);

        // Write then fetch of the same address.
        a_ctrl = 2'b10; a_addr = 16'h0020; a_wdata = 16'h5A5A; b_addr = 16'h0020;
        wait_ready(20);
        chk("wr_latency", edges, 6);
        chk("wr_we_low", we_low, 1);
        chk("wr_we_low_en", we_low_en, 1);
        chk("wr_mem", {16'd0, mem[16'h0020]}, 32'h5A5A);
        chk("wr_b_rdata", {16'd0, b_rdata}, 32'h5A5A);
        chk("wr_a_rdata", {16'd0, a_rdata}, 32'hBEEF);

        // Reset during the first write cycle.
        a_ctrl = 2'b10; a_addr = 16'h0030; a_wdata = 16'h7777; b_addr = 16'h0030;
        tick();
        tick();
        chk("mid_we_low", {31'd0, sram_we_n}, 32'h0);
        chk("mid_dout_en", {31'd0, sram_dout_en}, 32'h1);
        rst = 1'b0;
        tick();
        chk("mid_rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("mid_rst_dout_en", {31'd0, sram_dout_en}, 32'h0);
        chk("mid_rst_ready", {31'd0, ready}, 32'h0);
        rst = 1'b1;
        a_ctrl = 2'b01; a_addr = 16'h8000; b_addr = 16'h0010;
        tick();
        chk("post_rst_ready", {31'd0, ready}, 32'h0);
        wait_ready(20);
        chk("post_rst_latency", edges, 4);
        chk("post_rst_a_rdata", {16'd0, a_rdata}, 32'hBEEF);
        chk("post_rst_b_rdata", {16'd0, b_rdata}, 32'h4A21);

        // Reserved control code at the top of the address space.
        a_ctrl = 2'b11; a_addr = 16'hFFFF; b_addr = 16'hFFFF;
        wait_ready(20);
        chk("rsvd_latency", edges, 4);
        chk("rsvd_b_rdata", {16'd0, b_rdata}, 32'h0001);
        chk("rsvd_a_rdata", {16'd0, a_rdata}, 32'hBEEF);
        chk("rsvd_oe_low", oe_low, 2);
        chk("rsvd_we_low", we_low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
